// File: rtl/fifo_arb_pkg.sv
// Shared types and parameter helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Index width for NREQ requesters; never narrower than one bit.
    function automatic int idw_of(input int nreq);
        return (clog2(nreq) < 1) ? 1 : clog2(nreq);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set bit of req starting at start,
// wrapping modulo NREQ, with excl_last examined only after all others.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  start,
    input  logic [IDW-1:0]  excl_last,
    output logic            hit,
    output logic [IDW-1:0]  idx
);

    always_comb begin
        int unsigned pos;
        hit = 1'b0;
        idx = '0;
        pos = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            pos = (32'(start) + k) % NREQ;
            if (!hit && req[IDW'(pos)] && (IDW'(pos) != excl_last)) begin
                hit = 1'b1;
                idx = IDW'(pos);
            end
        end
        if (!hit && req[excl_last]) begin
            hit = 1'b1;
            idx = excl_last;
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ producers,
// holding each grant for up to BURST accepted beats.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int BURST = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    output logic [NREQ-1:0]         req_ready,
    input  logic                    fifo_full,
    output logic                    fifo_wr_en,
    output logic [WIDTH-1:0]        fifo_din,
    output logic                    grant_valid,
    output logic [idw_of(NREQ)-1:0] grant_id
);

    localparam int IDW = idw_of(NREQ);
    localparam int CW  = clog2(BURST + 1);

    state_t          state;
    logic [IDW-1:0]  owner;
    logic [IDW-1:0]  rr_ptr;
    logic [CW-1:0]   beat_cnt;

    logic            busy;
    logic            owner_valid;
    logic            release_now;
    logic [IDW-1:0]  next_owner;
    logic [IDW-1:0]  prev_ptr;
    logic [IDW-1:0]  pick_start;
    logic [IDW-1:0]  pick_last;
    logic            pick_hit;
    logic [IDW-1:0]  pick_idx;

    // One picker serves both the IDLE pick (from rr_ptr) and the release
    // re-pick (from owner+1, owner last); outputs stay combinational so
    // reset drops them asynchronously and fifo_full gates them same-cycle.
    always_comb begin
        busy        = (state == BUSY);
        owner_valid = req_valid[owner];
        next_owner  = (owner == IDW'(NREQ - 1)) ? '0 : owner + IDW'(1);
        prev_ptr    = (rr_ptr == '0) ? IDW'(NREQ - 1) : rr_ptr - IDW'(1);
        pick_start  = busy ? next_owner : rr_ptr;
        pick_last   = busy ? owner : prev_ptr;
        fifo_wr_en  = busy && owner_valid && !fifo_full;
        release_now = busy && (!owner_valid ||
                               (fifo_wr_en && (beat_cnt == CW'(BURST - 1))));
        grant_valid = busy;
        grant_id    = busy ? owner : '0;
        req_ready   = '0;
        fifo_din    = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (busy && (owner == IDW'(i))) begin
                req_ready[i] = !fifo_full;
                fifo_din     = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req       (req_valid),
        .start     (pick_start),
        .excl_last (pick_last),
        .hit       (pick_hit),
        .idx       (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_hit) begin
                        state    <= BUSY;
                        owner    <= pick_idx;
                        beat_cnt <= '0;
                    end
                end
                BUSY: begin
                    if (release_now) begin
                        rr_ptr   <= next_owner;
                        beat_cnt <= '0;
                        if (pick_hit) owner <= pick_idx;
                        else          state <= IDLE;
                    end else if (fifo_wr_en) begin
                        beat_cnt <= beat_cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: three configurations driven from one
// linear sequence, inputs set and outputs sampled just after the falling edge.
module tb_fifo_wr_arbiter;

    logic        clk;
    logic        rst_n;

    // Instance A: NREQ=4, BURST=4
    logic [3:0]  va, ra;
    logic [31:0] da;
    logic        fa, wa, gva;
    logic [7:0]  dina;
    logic [1:0]  gida;

    // Instance B: NREQ=4, BURST=2
    logic [3:0]  vb, rb;
    logic [31:0] db;
    logic        fb, wb, gvb;
    logic [7:0]  dinb;
    logic [1:0]  gidb;

    // Instance C: NREQ=3, BURST=2
    logic [2:0]  vc, rc;
    logic [23:0] dc;
    logic        fc, wc, gvc;
    logic [7:0]  dinc;
    logic [1:0]  gidc;

    int vectors;
    int miscompares;

    fifo_wr_arbiter #(.WIDTH(8), .NREQ(4), .BURST(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(va), .req_data(da), .req_ready(ra),
        .fifo_full(fa), .fifo_wr_en(wa), .fifo_din(dina),
        .grant_valid(gva), .grant_id(gida)
    );

    fifo_wr_arbiter #(.WIDTH(8), .NREQ(4), .BURST(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(vb), .req_data(db), .req_ready(rb),
        .fifo_full(fb), .fifo_wr_en(wb), .fifo_din(dinb),
        .grant_valid(gvb), .grant_id(gidb)
    );

    fifo_wr_arbiter #(.WIDTH(8), .NREQ(3), .BURST(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .req_valid(vc), .req_data(dc), .req_ready(rc),
        .fifo_full(fc), .fifo_wr_en(wc), .fifo_din(dinc),
        .grant_valid(gvc), .grant_id(gidc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic w, input logic [7:0] d,
                         input logic gv, input logic [1:0] gid, input logic [3:0] rdy);
        chk({tag, ".wr_en"}, 32'(wa), 32'(w));
        chk({tag, ".din"}, 32'(dina), 32'(d));
        chk({tag, ".gvalid"}, 32'(gva), 32'(gv));
        chk({tag, ".gid"}, 32'(gida), 32'(gid));
        chk({tag, ".ready"}, 32'(ra), 32'(rdy));
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        va = '0; da = '0; fa = 1'b0;
        vb = '0; db = '0; fb = 1'b0;
        vc = '0; dc = '0; fc = 1'b0;

        @(negedge clk); #1;
        chk_a("rst", 1'b0, 8'h00, 1'b0, 2'd0, 4'b0000);
        chk("rst.b.gvalid", 32'(gvb), 32'd0);
        chk("rst.c.ready", 32'(rc), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single requester 2, six beats, re-grant to itself after four
        @(negedge clk);
        va = 4'b0100; da[23:16] = 8'hA0; #1;
        chk_a("t1.idle", 1'b0, 8'h00, 1'b0, 2'd0, 4'b0000);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            da[23:16] = 8'hA0 + 8'(k); #1;
            chk_a($sformatf("t1.beat%0d", k), 1'b1, 8'hA0 + 8'(k), 1'b1, 2'd2, 4'b0100);
        end
        @(negedge clk);
        va = '0; #1;
        chk_a("t1.drop", 1'b0, 8'hA5, 1'b1, 2'd2, 4'b0100);
        @(negedge clk); #1;
        chk_a("t1.idle2", 1'b0, 8'h00, 1'b0, 2'd0, 4'b0000);

        // All four valid, BURST=2: grant order 0,0,1,1,2,2,3,3,0,0,...
        @(negedge clk);
        vb = 4'hF; db = {8'hB3, 8'hB2, 8'hB1, 8'hB0}; #1;
        chk("t2.idle.gvalid", 32'(gvb), 32'd0);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk); #1;
            chk($sformatf("t2.beat%0d.gid", k), 32'(gidb), 32'((k / 2) % 4));
            chk($sformatf("t2.beat%0d.din", k), 32'(dinb), 32'(8'hB0 + 8'((k / 2) % 4)));
            chk($sformatf("t2.beat%0d.wr_en", k), 32'(wb), 32'd1);
        end
        @(negedge clk);
        vb = '0; #1;
        chk("t2.drop.wr_en", 32'(wb), 32'd0);
        chk("t2.drop.gid", 32'(gidb), 32'd0);
        @(negedge clk); #1;
        chk("t2.idle2.gvalid", 32'(gvb), 32'd0);

        // Owner 1 stalled by fifo_full for three cycles, then rotates to 2
        @(negedge clk);
        va = 4'b0110; da = {8'h00, 8'hD0, 8'hC0, 8'h00}; #1;
        chk_a("t3.idle", 1'b0, 8'h00, 1'b0, 2'd0, 4'b0000);
        @(negedge clk); #1;
        chk_a("t3.b0", 1'b1, 8'hC0, 1'b1, 2'd1, 4'b0010);
        @(negedge clk);
        da[15:8] = 8'hC1; fa = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            chk_a($sformatf("t3.full%0d", k), 1'b0, 8'hC1, 1'b1, 2'd1, 4'b0000);
        end
        @(negedge clk);
        fa = 1'b0; #1;
        chk_a("t3.b1", 1'b1, 8'hC1, 1'b1, 2'd1, 4'b0010);
        @(negedge clk);
        da[15:8] = 8'hC2; #1;
        chk_a("t3.b2", 1'b1, 8'hC2, 1'b1, 2'd1, 4'b0010);
        @(negedge clk);
        da[15:8] = 8'hC3; #1;
        chk_a("t3.b3", 1'b1, 8'hC3, 1'b1, 2'd1, 4'b0010);
        @(negedge clk); #1;
        chk_a("t3.next", 1'b1, 8'hD0, 1'b1, 2'd2, 4'b0100);
        @(negedge clk);
        va = '0; #1;
        chk_a("t3.drop", 1'b0, 8'hD0, 1'b1, 2'd2, 4'b0100);
        @(negedge clk); #1;
        chk_a("t3.idle2", 1'b0, 8'h00, 1'b0, 2'd0, 4'b0000);

        // Owner 0 withdraws with 1 and 3 valid: 1 next, then 3 skipping 2
        @(negedge clk);
        va = 4'b0001; da = {8'hE3, 8'hE2, 8'hE1, 8'hE0}; #1;
        chk_a("t4.idle", 1'b0, 8'h00, 1'b0, 2'd0, 4'b0000);
        @(negedge clk); #1;
        chk_a("t4.o0a", 1'b1, 8'hE0, 1'b1, 2'd0, 4'b0001);
        @(negedge clk);
        va = 4'b1011; #1;
        chk_a("t4.o0b", 1'b1, 8'hE0, 1'b1, 2'd0, 4'b0001);
        @(negedge clk);
        va = 4'b1010; #1;
        chk_a("t4.drop", 1'b0, 8'hE0, 1'b1, 2'd0, 4'b0001);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            chk_a($sformatf("t4.o1.%0d", k), 1'b1, 8'hE1, 1'b1, 2'd1, 4'b0010);
        end
        @(negedge clk); #1;
        chk_a("t4.o3", 1'b1, 8'hE3, 1'b1, 2'd3, 4'b1000);
        @(negedge clk);
        va = '0; #1;
        chk_a("t4.end", 1'b0, 8'hE3, 1'b1, 2'd3, 4'b1000);
        @(negedge clk); #1;
        chk_a("t4.idle2", 1'b0, 8'h00, 1'b0, 2'd0, 4'b0000);

        // NREQ=3: owner 2 releases with only 0 valid, wraps to 0
        @(negedge clk);
        vc = 3'b100; dc = {8'hF2, 8'hF1, 8'hF0}; #1;
        chk("t5.idle.gvalid", 32'(gvc), 32'd0);
        @(negedge clk); #1;
        chk("t5.o2.gid", 32'(gidc), 32'd2);
        chk("t5.o2.din", 32'(dinc), 32'hF2);
        @(negedge clk);
        vc = 3'b001; #1;
        chk("t5.drop.wr_en", 32'(wc), 32'd0);
        chk("t5.drop.gid", 32'(gidc), 32'd2);
        @(negedge clk); #1;
        chk("t5.wrap.gid", 32'(gidc), 32'd0);
        chk("t5.wrap.gvalid", 32'(gvc), 32'd1);
        chk("t5.wrap.din", 32'(dinc), 32'hF0);
        chk("t5.wrap.ready", 32'(rc), 32'b001);
        @(negedge clk);
        vc = '0; #1;
        chk("t5.end.wr_en", 32'(wc), 32'd0);
        @(negedge clk); #1;
        chk("t5.idle2.gvalid", 32'(gvc), 32'd0);

        // Reset mid-burst with rr_ptr=1; arbitration restarts from 0
        @(negedge clk);
        va = 4'b1001; #1;
        chk_a("t6.idle", 1'b0, 8'h00, 1'b0, 2'd0, 4'b0000);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            chk_a($sformatf("t6.o0.%0d", k), 1'b1, 8'hE0, 1'b1, 2'd0, 4'b0001);
        end
        @(negedge clk); #1;
        chk_a("t6.o3", 1'b1, 8'hE3, 1'b1, 2'd3, 4'b1000);
        #1 rst_n = 1'b0;
        #1;
        chk_a("t6.rst", 1'b0, 8'h00, 1'b0, 2'd0, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1; #1;
        chk_a("t6.post", 1'b0, 8'h00, 1'b0, 2'd0, 4'b0000);
        @(negedge clk); #1;
        chk_a("t6.restart", 1'b1, 8'hE0, 1'b1, 2'd0, 4'b0001);
        @(negedge clk);
        va = '0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
